// File: rtl/gpu_regs_pkg.sv
// gpu_regs_pkg: register map, bit indices and AXI response codes for gpu_regs.
// Honours GPU_REGS_FRAME_COUNTER_EN (FRAME_COUNT register present when defined).
package gpu_regs_pkg;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_TRI    = 3'd2;
  localparam logic [2:0] OFF_VBASE  = 3'd3;
  localparam logic [2:0] OFF_CBASE  = 3'd4;
  localparam logic [2:0] OFF_FCOUNT = 3'd5;
  localparam logic [2:0] OFF_ID     = 3'd6;
  localparam logic [2:0] OFF_NONE   = 3'd7;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;

  localparam logic [31:0] GPU_ID = 32'h4750_5530;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  // Byte-lane merge of new data into an old word.
  function automatic logic [31:0] strb_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  // Offsets that decode to a real register.
  function automatic logic is_mapped(input logic [2:0] off);
`ifdef GPU_REGS_FRAME_COUNTER_EN
    return off != OFF_NONE;
`else
    return (off != OFF_NONE) && (off != OFF_FCOUNT);
`endif
  endfunction

endpackage

// File: rtl/gpu_regs.sv
// gpu_regs: AXI4-lite register target driving the GPU frame state machine.
// Optional FRAME_COUNT register enabled by GPU_REGS_FRAME_COUNTER_EN.
module gpu_regs
  import gpu_regs_pkg::*;
#(
  parameter int SADDR_WIDTH = 32,
  parameter int MADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [SADDR_WIDTH-1:0] awaddr,
  input  logic [2:0]             awprot,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic [SADDR_WIDTH-1:0] araddr,
  input  logic [2:0]             arprot,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [31:0]            rdata,
  output logic [1:0]             rresp,
  output logic                   rvalid,
  input  logic                   rready,
  output logic                   frame_start,
  input  logic                   frame_end,
  output logic [31:0]            triangles_count,
  output logic [MADDR_WIDTH-1:0] base_addr_vertex,
  output logic [MADDR_WIDTH-1:0] base_addr_color,
  output logic                   irq
);

  logic        r_live;
  logic        r_aw_held;
  logic [2:0]  r_aw_off;
  logic        r_w_held;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_bvalid;
  axi_resp_e   r_bresp;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  axi_resp_e   r_rresp;
  logic        r_irq_en;
  logic        r_busy;
  logic        r_done;
  logic        r_frame_start;
  logic [31:0] r_tri;
  logic [31:0] r_vbase;
  logic [31:0] r_cbase;
`ifdef GPU_REGS_FRAME_COUNTER_EN
  logic [31:0] r_fcount;
`endif

  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_ar_hs;
  logic        w_commit;
  logic [2:0]  w_off;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_start;
  logic        w_start_err;
  logic        w_start_go;
  logic        w_start_nil;
  logic        w_done_clr;
  logic        w_fend;
  axi_resp_e   w_wr_resp;
  logic [31:0] w_rd_data;
  axi_resp_e   w_rd_resp;
  logic        w_unused;

  assign w_unused = ^{awprot, arprot,
                      awaddr[SADDR_WIDTH-1:5], awaddr[1:0],
                      araddr[SADDR_WIDTH-1:5], araddr[1:0]};

  assign awready = r_live & ~r_aw_held & ~r_bvalid;
  assign wready  = r_live & ~r_w_held & ~r_bvalid;
  assign arready = r_live & ~r_rvalid;

  assign w_aw_hs  = awvalid & awready;
  assign w_w_hs   = wvalid & wready;
  assign w_ar_hs  = arvalid & arready;
  assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs)
                  & ~r_bvalid;

  assign w_off  = r_aw_held ? r_aw_off : awaddr[4:2];
  assign w_data = r_w_held ? r_wdata : wdata;
  assign w_strb = r_w_held ? r_wstrb : wstrb;

  assign w_start     = w_commit && (w_off == OFF_CTRL) && w_strb[0]
                     && w_data[CTRL_START];
  assign w_start_err = w_start && r_busy;
  assign w_start_go  = w_start && !r_busy && (r_tri != '0);
  assign w_start_nil = w_start && !r_busy && (r_tri == '0);
  assign w_done_clr  = w_commit && (w_off == OFF_STATUS) && w_strb[0]
                     && w_data[STAT_DONE];
  assign w_fend      = frame_end && r_busy;

  assign w_wr_resp = (!is_mapped(w_off) || w_start_err) ? RESP_SLVERR
                                                        : RESP_OKAY;

  assign bvalid           = r_bvalid;
  assign bresp            = r_bresp;
  assign rvalid           = r_rvalid;
  assign rdata            = r_rdata;
  assign rresp            = r_rresp;
  assign frame_start      = r_frame_start;
  assign triangles_count  = r_tri;
  assign base_addr_vertex = r_vbase[MADDR_WIDTH-1:0];
  assign base_addr_color  = r_cbase[MADDR_WIDTH-1:0];
  assign irq              = r_done & r_irq_en;

  // Write channel: hold AW/W independently, commit when both present.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_live    <= 1'b0;
      r_aw_held <= 1'b0;
      r_aw_off  <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_live <= 1'b1;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_resp;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_aw_off  <= awaddr[4:2];
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= wdata;
          r_wstrb  <= wstrb;
        end
        if (r_bvalid && bready) r_bvalid <= 1'b0;
      end
    end
  end

  // Configuration registers written by committed transactions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en <= 1'b0;
      r_tri    <= '0;
      r_vbase  <= '0;
      r_cbase  <= '0;
    end else if (w_commit) begin
      case (w_off)
        OFF_CTRL:  if (w_strb[0]) r_irq_en <= w_data[CTRL_IRQ_EN];
        OFF_TRI:   r_tri   <= strb_merge(r_tri, w_data, w_strb);
        OFF_VBASE: r_vbase <= strb_merge(r_vbase, w_data, w_strb);
        OFF_CBASE: r_cbase <= strb_merge(r_cbase, w_data, w_strb);
        default:   ;
      endcase
    end
  end

  // Frame status: start pulse, BUSY/DONE, frame counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
`ifdef GPU_REGS_FRAME_COUNTER_EN
      r_fcount      <= '0;
`endif
    end else begin
      r_frame_start <= w_start_go;
      if (w_fend) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else if (w_start_go) begin
        r_busy <= 1'b1;
        r_done <= 1'b0;
      end else if (w_start_nil) begin
        r_done <= 1'b1;
      end else if (w_done_clr) begin
        r_done <= 1'b0;
      end
`ifdef GPU_REGS_FRAME_COUNTER_EN
      if (w_fend) r_fcount <= r_fcount + 32'd1;
`endif
    end
  end

  // Read decode of the current (pre-commit) register values.
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    case (araddr[4:2])
      OFF_CTRL:   w_rd_data[CTRL_IRQ_EN] = r_irq_en;
      OFF_STATUS: begin
        w_rd_data[STAT_BUSY] = r_busy;
        w_rd_data[STAT_DONE] = r_done;
      end
      OFF_TRI:    w_rd_data = r_tri;
      OFF_VBASE:  w_rd_data = r_vbase;
      OFF_CBASE:  w_rd_data = r_cbase;
`ifdef GPU_REGS_FRAME_COUNTER_EN
      OFF_FCOUNT: w_rd_data = r_fcount;
`endif
      OFF_ID:     w_rd_data = GPU_ID;
      default:    w_rd_resp = RESP_SLVERR;
    endcase
  end

  // Read channel: one outstanding read, registered data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end else if (r_rvalid && rready) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpu_regs.sv
// tb_gpu_regs: directed plus randomized bench for gpu_regs.
// Expectations follow GPU_REGS_FRAME_COUNTER_EN when it is defined.
module tb_gpu_regs;

`ifdef GPU_REGS_FRAME_COUNTER_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        frame_start;
  logic        frame_end = 1'b0;
  logic [31:0] triangles_count;
  logic [31:0] base_addr_vertex;
  logic [31:0] base_addr_color;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: the programmer-visible registers.
  logic [31:0] m_tri, m_vb, m_cb, m_fc;
  logic        m_irqen, m_busy, m_done;

  gpu_regs dut (
    .clk(clk), .reset_n(reset_n),
    .awaddr(awaddr), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb),
    .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp),
    .rvalid(rvalid), .rready(rready),
    .frame_start(frame_start), .frame_end(frame_end),
    .triangles_count(triangles_count),
    .base_addr_vertex(base_addr_vertex),
    .base_addr_color(base_addr_color),
    .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_write(input int off, input logic [31:0] d,
                             input logic [3:0] s,
                             output logic [1:0] resp,
                             output logic pulse);
    resp  = 2'b00;
    pulse = 1'b0;
    case (off)
      0: if (s[0]) begin
        m_irqen = d[1];
        if (d[0]) begin
          if (m_busy) resp = 2'b10;
          else if (m_tri != 0) begin
            pulse = 1'b1; m_busy = 1'b1; m_done = 1'b0;
          end else m_done = 1'b1;
        end
      end
      1: if (s[0] && d[1]) m_done = 1'b0;
      2: m_tri = merge(m_tri, d, s);
      3: m_vb = merge(m_vb, d, s);
      4: m_cb = merge(m_cb, d, s);
      5: resp = FC_EN ? 2'b00 : 2'b10;
      6: resp = 2'b00;
      default: resp = 2'b10;
    endcase
  endtask

  task automatic model_read(input int off, output logic [31:0] d,
                            output logic [1:0] resp);
    d = 0;
    resp = 2'b00;
    case (off)
      0: d = {30'd0, m_irqen, 1'b0};
      1: d = {30'd0, m_done, m_busy};
      2: d = m_tri;
      3: d = m_vb;
      4: d = m_cb;
      5: if (FC_EN) d = m_fc; else resp = 2'b10;
      6: d = 32'h4750_5530;
      default: resp = 2'b10;
    endcase
  endtask

  task automatic model_fend();
    if (m_busy) begin
      m_busy = 1'b0; m_done = 1'b1; m_fc = m_fc + 1;
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_tri"}, triangles_count, m_tri);
    chk({tag, "_vb"}, base_addr_vertex, m_vb);
    chk({tag, "_cb"}, base_addr_color, m_cb);
    chk({tag, "_irq"}, irq, m_done & m_irqen);
  endtask

  // Bus-level write; called and returns on a falling edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int adly, input int wdly,
                    input int hold, output logic [1:0] resp,
                    output logic fs1, output logic fs2);
    fork
      begin
        repeat (adly) @(negedge clk);
        awaddr = a; awvalid = 1'b1;
        for (int i = 0; i < 40 && !awready; i++) @(negedge clk);
        if (!awready) chk("aw_timeout", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
      end
      begin
        repeat (wdly) @(negedge clk);
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int j = 0; j < 40 && !wready; j++) @(negedge clk);
        if (!wready) chk("w_timeout", wready, 1);
        @(negedge clk);
        wvalid = 1'b0;
      end
    join
    for (int i = 0; i < 40 && !bvalid; i++) @(negedge clk);
    chk("bvalid_rise", bvalid, 1);
    resp = bresp;
    fs1  = frame_start;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_bvalid", bvalid, 1);
      chk("hold_bresp", bresp, resp);
      chk("hold_awready", awready, 0);
      chk("hold_wready", wready, 0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    fs2 = frame_start;
    chk("bvalid_fall", bvalid, 0);
  endtask

  task automatic rd(input logic [31:0] a, input int hold,
                    output logic [31:0] d, output logic [1:0] resp);
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 40 && !arready; i++) @(negedge clk);
    if (!arready) chk("ar_timeout", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i < 40 && !rvalid; i++) @(negedge clk);
    chk("rvalid_rise", rvalid, 1);
    d = rdata;
    resp = rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rvalid", rvalid, 1);
      chk("hold_rdata", rdata, d);
      chk("hold_arready", arready, 0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic wcheck(input string tag, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input int adly, input int wdly, input int hold);
    logic [1:0] er, r;
    logic ep, f1, f2;
    model_write(int'(a[4:2]), d, s, er, ep);
    wr(a, d, s, adly, wdly, hold, r, f1, f2);
    chk({tag, "_bresp"}, r, er);
    chk({tag, "_fstart"}, f1, ep);
    chk({tag, "_fstart_end"}, f2, 0);
    chk_outs(tag);
  endtask

  task automatic rcheck(input string tag, input logic [31:0] a,
                        input int hold);
    logic [31:0] ed, d;
    logic [1:0] er, r;
    model_read(int'(a[4:2]), ed, er);
    rd(a, hold, d, r);
    chk({tag, "_rdata"}, d, ed);
    chk({tag, "_rresp"}, r, er);
  endtask

  task automatic pulse_fend();
    frame_end = 1'b1;
    model_fend();
    @(negedge clk);
    frame_end = 1'b0;
    chk("fend_irq", irq, m_done & m_irqen);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0] s;
    int off;
    m_tri = 0; m_vb = 0; m_cb = 0; m_fc = 0;
    m_irqen = 0; m_busy = 0; m_done = 0;

    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_fstart", frame_start, 0);
    chk_outs("rst");
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_awready", awready, 1);
    chk("post_wready", wready, 1);
    chk("post_arready", arready, 1);

    wcheck("w_tri", 32'h08, 32'd5, 4'hF, 0, 3, 0);
    wcheck("w_vb", 32'h0C, 32'h1000, 4'hF, 3, 0, 0);
    wcheck("w_cb", 32'h10, 32'h2000, 4'hF, 0, 3, 0);
    rcheck("r_tri", 32'h08, 0);
    rcheck("r_vb", 32'h0C, 0);
    rcheck("r_cb", 32'h10, 0);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        off = $urandom_range(2, 7);
        a = ($urandom & ~32'h1C) | (32'(off) << 2);
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        wcheck("rnd_w", a, d, s, $urandom_range(0, 3),
               $urandom_range(0, 3), 0);
      end else begin
        off = $urandom_range(0, 7);
        a = ($urandom & ~32'h1C) | (32'(off) << 2);
        rcheck("rnd_r", a, 0);
      end
    end

    wcheck("tri5", 32'h08, 32'd5, 4'hF, 0, 0, 0);
    wcheck("start1", 32'h00, 32'h3, 4'h1, 0, 0, 0);
    rcheck("st_busy", 32'h04, 0);
    wcheck("start_busy", 32'h00, 32'h3, 4'h1, 1, 0, 0);
    pulse_fend();
    rcheck("st_done", 32'h04, 0);
    wcheck("clr_done", 32'h04, 32'h2, 4'h1, 0, 0, 0);

    wcheck("start2", 32'h00, 32'h3, 4'h1, 0, 2, 0);
    awaddr = 32'h04; wdata = 32'h2; wstrb = 4'h1;
    awvalid = 1'b1; wvalid = 1'b1; frame_end = 1'b1;
    model_write(1, 32'h2, 4'h1, s[1:0], s[2]);
    model_fend();
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; frame_end = 1'b0;
    chk("coinc_bvalid", bvalid, 1);
    chk("coinc_bresp", bresp, 0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk_outs("coinc");
    rcheck("coinc_st", 32'h04, 0);

    wcheck("start3", 32'h00, 32'h3, 4'h1, 0, 0, 0);
    pulse_fend();
    pulse_fend();
    rcheck("fcount", 32'h14, 0);

    wcheck("tri0", 32'h08, 32'h0, 4'hF, 0, 0, 0);
    wcheck("strb", 32'h08, 32'hAABBCCDD, 4'b0010, 0, 0, 0);
    chk("strb_const", triangles_count, 32'h0000CC00);
    rcheck("id", 32'h18, 0);
    rcheck("unmapped", 32'h1C, 0);
    rcheck("alias", 32'h28, 0);

    wcheck("tri_z", 32'h08, 32'h0, 4'hF, 0, 0, 0);
    wcheck("clr2", 32'h04, 32'h2, 4'h1, 0, 0, 0);
    wcheck("start_nil", 32'h00, 32'h3, 4'h1, 0, 0, 0);
    rcheck("st_nil", 32'h04, 0);

    fork
      wcheck("hold_w", 32'h0C, $urandom, 4'hF, 0, 0, 10);
      rcheck("hold_r", 32'h08, 10);
    join

    @(negedge clk);
    awaddr = 32'h10; wdata = 32'h55AA; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h18; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("pre_rst_bvalid", bvalid, 1);
    chk("pre_rst_rvalid", rvalid, 1);
    chk("pre_rst_irq", irq, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_bvalid", bvalid, 0);
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_awready", awready, 0);
    chk("mid_rst_arready", arready, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_tri", triangles_count, 0);
    chk("mid_rst_cb", base_addr_color, 0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
